// File: rtl/idma_inst64_cmd_sequencer.sv
// Decodes Snitch inst64 DMA offloads into iDMA backend requests. It keeps the transfer
// configuration in shadow registers and counts issued and completed transfers.
module idma_inst64_cmd_sequencer #(
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned UserWidth      = 32,
  parameter int unsigned IdWidth        = 32,
  parameter int unsigned MaxOutstanding = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 acc_qvalid_i,
  output logic                 acc_qready_o,
  input  logic [31:0]          acc_qdata_op_i,
  input  logic [63:0]          acc_qdata_arga_i,
  input  logic [63:0]          acc_qdata_argb_i,
  input  logic [4:0]           acc_qid_i,
  output logic                 acc_pvalid_o,
  input  logic                 acc_pready_i,
  output logic [63:0]          acc_pdata_o,
  output logic [4:0]           acc_pid_o,
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  output logic [AddrWidth-1:0] req_src_o,
  output logic [AddrWidth-1:0] req_dst_o,
  output logic [AddrWidth-1:0] req_len_o,
  output logic [AddrWidth-1:0] req_src_stride_o,
  output logic [AddrWidth-1:0] req_dst_stride_o,
  output logic [AddrWidth-1:0] req_reps_o,
  output logic                 req_2d_o,
  output logic                 req_decouple_o,
  output logic [UserWidth-1:0] req_user_o,
  input  logic                 rsp_valid_i,
  output logic                 busy_o,
  output logic                 illegal_o
);

  typedef enum logic [1:0] {StIdle = 2'd0, StIssue = 2'd1, StResp = 2'd2} state_e;
  typedef enum logic [3:0] {
    KIllegal = 4'd0, KSrc = 4'd1, KDst = 4'd2, KCpyi = 4'd3, KCpy = 4'd4,
    KStati = 4'd5, KStat = 4'd6, KStr = 4'd7, KRep = 4'd8, KUser = 4'd9
  } kind_e;

  localparam logic [IdWidth-1:0] MaxOut = IdWidth'(MaxOutstanding);

  state_e                 state_q, state_d;
  kind_e                  kind_s;
  logic [AddrWidth-1:0]   src_q, src_d, dst_q, dst_d, len_q, len_d;
  logic [AddrWidth-1:0]   sstr_q, sstr_d, dstr_q, dstr_d, reps_q, reps_d;
  logic [UserWidth-1:0]   user_q, user_d;
  logic [1:0]             cfg_q, cfg_d;
  logic [IdWidth-1:0]     issue_q, issue_d, done_q, done_d, out_d, outstanding_s;
  logic                   qready_q, qready_d, pvalid_q, pvalid_d, req_valid_q, req_valid_d;
  logic                   busy_q, busy_d, illegal_q, illegal_d;
  logic [63:0]            pdata_q, pdata_d, status_s, pair_s;
  logic [4:0]             pid_q, pid_d, rd_s, rs1_s, rs2_s, sel_s, cfg_sel_s;
  logic                   accept_s, hs_s, comp_s;

  assign rd_s          = acc_qdata_op_i[11:7];
  assign rs1_s         = acc_qdata_op_i[19:15];
  assign rs2_s         = acc_qdata_op_i[24:20];
  assign pair_s        = {acc_qdata_argb_i[31:0], acc_qdata_arga_i[31:0]};
  assign outstanding_s = issue_q - done_q;
  assign accept_s      = acc_qvalid_i & qready_q;
  assign hs_s          = req_valid_q & req_ready_i;
  assign comp_s        = rsp_valid_i & (outstanding_s != '0);

  // Instruction decode, including the must-be-zero register fields.
  always_comb begin
    kind_s = KIllegal;
    if ((acc_qdata_op_i[6:0] == 7'b0101011) && (acc_qdata_op_i[14:12] == 3'b000)) begin
      case (acc_qdata_op_i[31:25])
        7'b0000000: kind_s = (rd_s == 5'd0) ? KSrc : KIllegal;
        7'b0000001: kind_s = (rd_s == 5'd0) ? KDst : KIllegal;
        7'b0000010: kind_s = KCpyi;
        7'b0000011: kind_s = KCpy;
        7'b0000100: kind_s = (rs1_s == 5'd0) ? KStati : KIllegal;
        7'b0000101: kind_s = (rs1_s == 5'd0) ? KStat : KIllegal;
        7'b0000110: kind_s = (rd_s == 5'd0) ? KStr : KIllegal;
        7'b0000111: kind_s = ((rd_s == 5'd0) && (rs2_s == 5'd0)) ? KRep : KIllegal;
        7'b0001000: kind_s = (rd_s == 5'd0) ? KUser : KIllegal;
        default:    kind_s = KIllegal;
      endcase
    end else begin
      kind_s = KIllegal;
    end
  end

  // Status word returned by DMSTAT/DMSTATI, evaluated in the accept cycle.
  always_comb begin
    sel_s     = (kind_s == KStati) ? rs2_s : acc_qdata_argb_i[4:0];
    cfg_sel_s = (kind_s == KCpyi) ? rs2_s : acc_qdata_argb_i[4:0];
    case (sel_s)
      5'd0:    status_s = 64'(done_q);
      5'd1:    status_s = 64'(issue_q);
      5'd2:    status_s = {63'd0, (outstanding_s != '0)};
      5'd3:    status_s = {63'd0, (outstanding_s == MaxOut)};
      default: status_s = 64'd0;
    endcase
  end

  // Next-state logic for the sequencer, shadow registers and transfer counters.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    sstr_d    = sstr_q;
    dstr_d    = dstr_q;
    reps_d    = reps_q;
    user_d    = user_q;
    cfg_d     = cfg_q;
    pvalid_d  = pvalid_q;
    pdata_d   = pdata_q;
    pid_d     = pid_q;
    illegal_d = 1'b0;
    issue_d   = hs_s ? (issue_q + IdWidth'(1)) : issue_q;
    done_d    = comp_s ? (done_q + IdWidth'(1)) : done_q;
    case (state_q)
      StIdle: begin
        if (accept_s) begin
          case (kind_s)
            KSrc:  src_d  = pair_s[AddrWidth-1:0];
            KDst:  dst_d  = pair_s[AddrWidth-1:0];
            KStr: begin
              sstr_d = acc_qdata_arga_i[AddrWidth-1:0];
              dstr_d = acc_qdata_argb_i[AddrWidth-1:0];
            end
            KRep:  reps_d = acc_qdata_arga_i[AddrWidth-1:0];
            KUser: user_d = pair_s[UserWidth-1:0];
            KCpyi, KCpy: begin
              len_d   = acc_qdata_arga_i[AddrWidth-1:0];
              cfg_d   = cfg_sel_s[1:0];
              pid_d   = acc_qid_i;
              state_d = StIssue;
            end
            KStati, KStat: begin
              pid_d    = acc_qid_i;
              pdata_d  = status_s;
              pvalid_d = 1'b1;
              state_d  = StResp;
            end
            default: illegal_d = 1'b1;
          endcase
        end else begin
          state_d = StIdle;
        end
      end
      StIssue: begin
        if (hs_s) begin
          pdata_d  = 64'(issue_q);
          pvalid_d = 1'b1;
          state_d  = StResp;
        end else begin
          state_d = StIssue;
        end
      end
      StResp: begin
        if (acc_pready_i) begin
          pvalid_d = 1'b0;
          state_d  = StIdle;
        end else begin
          state_d = StResp;
        end
      end
      default: begin
        pvalid_d = 1'b0;
        state_d  = StIdle;
      end
    endcase
    // Outputs are registered, so they are derived from the next-cycle counters.
    out_d       = issue_d - done_d;
    req_valid_d = (state_d == StIssue) && (out_d < MaxOut);
    qready_d    = (state_d == StIdle);
    busy_d      = (out_d != '0);
  end

  // State, shadow and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      sstr_q      <= '0;
      dstr_q      <= '0;
      reps_q      <= '0;
      user_q      <= '0;
      cfg_q       <= 2'b00;
      issue_q     <= '0;
      done_q      <= '0;
      qready_q    <= 1'b1;
      pvalid_q    <= 1'b0;
      pdata_q     <= 64'd0;
      pid_q       <= 5'd0;
      req_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      sstr_q      <= sstr_d;
      dstr_q      <= dstr_d;
      reps_q      <= reps_d;
      user_q      <= user_d;
      cfg_q       <= cfg_d;
      issue_q     <= issue_d;
      done_q      <= done_d;
      qready_q    <= qready_d;
      pvalid_q    <= pvalid_d;
      pdata_q     <= pdata_d;
      pid_q       <= pid_d;
      req_valid_q <= req_valid_d;
      busy_q      <= busy_d;
      illegal_q   <= illegal_d;
    end
  end

  assign acc_qready_o     = qready_q;
  assign acc_pvalid_o     = pvalid_q;
  assign acc_pdata_o      = pdata_q;
  assign acc_pid_o        = pid_q;
  assign req_valid_o      = req_valid_q;
  assign req_src_o        = src_q;
  assign req_dst_o        = dst_q;
  assign req_len_o        = len_q;
  assign req_src_stride_o = sstr_q;
  assign req_dst_stride_o = dstr_q;
  assign req_reps_o       = reps_q;
  assign req_2d_o         = cfg_q[1];
  assign req_decouple_o   = cfg_q[0];
  assign req_user_o       = user_q;
  assign busy_o           = busy_q;
  assign illegal_o        = illegal_q;

endmodule

// File: tb/tb_idma_inst64_cmd_sequencer.sv
// Randomised self-checking bench for idma_inst64_cmd_sequencer against a
// transaction-level model of the shadow registers and transfer counters.
module tb_idma_inst64_cmd_sequencer;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        acc_qvalid_i = 1'b0, acc_qready_o;
  logic [31:0] acc_qdata_op_i = 32'd0;
  logic [63:0] acc_qdata_arga_i = 64'd0, acc_qdata_argb_i = 64'd0;
  logic [4:0]  acc_qid_i = 5'd0;
  logic        acc_pvalid_o, acc_pready_i = 1'b0;
  logic [63:0] acc_pdata_o;
  logic [4:0]  acc_pid_o;
  logic        req_valid_o, req_ready_i = 1'b0;
  logic [63:0] req_src_o, req_dst_o, req_len_o, req_src_stride_o, req_dst_stride_o, req_reps_o;
  logic        req_2d_o, req_decouple_o;
  logic [31:0] req_user_o;
  logic        rsp_valid_i = 1'b0, busy_o, illegal_o;

  always #5 clk_i = ~clk_i;

  idma_inst64_cmd_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .acc_qvalid_i(acc_qvalid_i), .acc_qready_o(acc_qready_o),
    .acc_qdata_op_i(acc_qdata_op_i), .acc_qdata_arga_i(acc_qdata_arga_i),
    .acc_qdata_argb_i(acc_qdata_argb_i), .acc_qid_i(acc_qid_i),
    .acc_pvalid_o(acc_pvalid_o), .acc_pready_i(acc_pready_i),
    .acc_pdata_o(acc_pdata_o), .acc_pid_o(acc_pid_o),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .req_src_o(req_src_o), .req_dst_o(req_dst_o), .req_len_o(req_len_o),
    .req_src_stride_o(req_src_stride_o), .req_dst_stride_o(req_dst_stride_o),
    .req_reps_o(req_reps_o), .req_2d_o(req_2d_o), .req_decouple_o(req_decouple_o),
    .req_user_o(req_user_o), .rsp_valid_i(rsp_valid_i), .busy_o(busy_o), .illegal_o(illegal_o)
  );

  localparam logic [6:0] F_SRC = 7'd0, F_DST = 7'd1, F_CPYI = 7'd2, F_CPY = 7'd3;
  localparam logic [6:0] F_STATI = 7'd4, F_STAT = 7'd5, F_STR = 7'd6, F_REP = 7'd7, F_USER = 7'd8;

  int n_total = 0, n_pass = 0;

  // Reference model: architectural view of the configuration and counters.
  logic [63:0] m_src, m_dst, m_sstr, m_dstr, m_reps;
  logic [31:0] m_user, m_issue, m_done;
  logic [1:0]  m_cfg;
  logic [63:0] m_len;

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [4:0] rd);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0101011};
  endfunction

  function automatic logic [63:0] m_status(input logic [4:0] sel);
    int unsigned outs;
    outs = m_issue - m_done;
    case (sel)
      5'd0:    return {32'd0, m_done};
      5'd1:    return {32'd0, m_issue};
      5'd2:    return (outs != 0) ? 64'd1 : 64'd0;
      5'd3:    return (outs == 8) ? 64'd1 : 64'd0;
      default: return 64'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_src = 64'd0; m_dst = 64'd0; m_sstr = 64'd0; m_dstr = 64'd0; m_reps = 64'd0;
    m_user = 32'd0; m_issue = 32'd0; m_done = 32'd0; m_cfg = 2'd0; m_len = 64'd0;
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    rst_i = 1'b1; acc_qvalid_i = 1'b0; acc_pready_i = 1'b0; req_ready_i = 1'b0; rsp_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
  endtask

  task automatic send_op(input logic [31:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] qid);
    int waited;
    waited = 0;
    while (acc_qready_o !== 1'b1 && waited < 200) begin
      @(negedge clk_i);
      waited++;
    end
    if (acc_qready_o !== 1'b1) begin
      n_total++;
      $display("FAIL send_op_timeout: qready=%b required 1", acc_qready_o);
    end else begin
      acc_qvalid_i = 1'b1; acc_qdata_op_i = op; acc_qdata_arga_i = a; acc_qdata_argb_i = b;
      acc_qid_i = qid;
      @(negedge clk_i);
      acc_qvalid_i = 1'b0;
    end
  endtask

  task automatic wait_req(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (req_valid_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
  endtask

  task automatic handshake();
    req_ready_i = 1'b1;
    @(negedge clk_i);
    req_ready_i = 1'b0;
  endtask

  task automatic take_wb(output logic [63:0] d, output logic [4:0] pid, output bit seen);
    seen = 1'b0; d = 64'd0; pid = 5'd0;
    for (int i = 0; i < 50; i++) begin
      if (acc_pvalid_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    if (seen) begin
      d = acc_pdata_o; pid = acc_pid_o;
      acc_pready_i = 1'b1;
      @(negedge clk_i);
      acc_pready_i = 1'b0;
    end
  endtask

  task automatic pulse_rsp();
    rsp_valid_i = 1'b1;
    @(negedge clk_i);
    rsp_valid_i = 1'b0;
    if (m_issue != m_done) m_done = m_done + 32'd1;
  endtask

  task automatic wr_src(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] p;
    send_op(enc(F_SRC, 5'($urandom), 5'($urandom), 5'd0), a, b, 5'($urandom));
    p = {b[31:0], a[31:0]}; m_src = p;
  endtask

  task automatic wr_dst(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] p;
    send_op(enc(F_DST, 5'($urandom), 5'($urandom), 5'd0), a, b, 5'($urandom));
    p = {b[31:0], a[31:0]}; m_dst = p;
  endtask

  task automatic wr_str(input logic [63:0] a, input logic [63:0] b);
    send_op(enc(F_STR, 5'($urandom), 5'($urandom), 5'd0), a, b, 5'($urandom));
    m_sstr = a; m_dstr = b;
  endtask

  task automatic wr_rep(input logic [63:0] a);
    send_op(enc(F_REP, 5'd0, 5'($urandom), 5'd0), a, {$urandom, $urandom}, 5'($urandom));
    m_reps = a;
  endtask

  task automatic wr_user(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] p;
    send_op(enc(F_USER, 5'($urandom), 5'($urandom), 5'd0), a, b, 5'($urandom));
    p = {b[31:0], a[31:0]}; m_user = p[31:0];
  endtask

  // Issues one copy; returns whether the request and writeback showed up and the ID.
  task automatic do_copy(input bit imm, input logic [63:0] len, input logic [4:0] cfg,
                         input logic [4:0] qid, output bit seen_req, output bit seen_wb,
                         output logic [63:0] d, output logic [4:0] pid);
    logic [63:0] b;
    if (imm) begin
      b = {$urandom, $urandom};
      send_op(enc(F_CPYI, cfg, 5'($urandom), qid), len, b, qid);
    end else begin
      b = {$urandom, $urandom};
      b[4:0] = cfg;
      send_op(enc(F_CPY, 5'($urandom), 5'($urandom), qid), len, b, qid);
    end
    m_len = len; m_cfg = cfg[1:0];
    wait_req(seen_req);
    if (seen_req) handshake();
    take_wb(d, pid, seen_wb);
  endtask

  task automatic do_stat(input bit imm, input logic [4:0] sel, input logic [4:0] qid,
                         output logic [63:0] d, output logic [4:0] pid, output bit seen);
    logic [63:0] b;
    b = {$urandom, $urandom};
    if (imm) begin
      send_op(enc(F_STATI, sel, 5'd0, qid), {$urandom, $urandom}, b, qid);
    end else begin
      b[4:0] = sel;
      send_op(enc(F_STAT, 5'($urandom), 5'd0, qid), {$urandom, $urandom}, b, qid);
    end
    take_wb(d, pid, seen);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    model_reset();
    n_total++; if (acc_qready_o !== 1'b1) $display("FAIL reset_qready: got %b required 1", acc_qready_o); else n_pass++;
    rst_i = 1'b0;
    @(negedge clk_i);
    n_total++; if (acc_qready_o !== 1'b1) $display("FAIL reset_qready_after: got %b required 1", acc_qready_o); else n_pass++;
    n_total++; if ({acc_pvalid_o, req_valid_o, illegal_o, busy_o} !== 4'b0000)
      $display("FAIL reset_valids: got %b required 0000", {acc_pvalid_o, req_valid_o, illegal_o, busy_o}); else n_pass++;
    n_total++; if ({req_src_o, req_dst_o, req_reps_o} !== 192'd0 || req_2d_o !== 1'b0 || req_user_o !== 32'd0)
      $display("FAIL reset_shadow: src=%h dst=%h reps=%h 2d=%b user=%h required all 0",
               req_src_o, req_dst_o, req_reps_o, req_2d_o, req_user_o); else n_pass++;
  endtask

  task automatic test_basic_copy();
    logic [63:0] d; logic [4:0] pid; bit seen;
    apply_reset();
    wr_src(64'h1000, 64'h1);
    wr_dst(64'h2000, 64'h0);
    send_op(enc(F_CPYI, 5'd0, 5'd10, 5'd5), 64'd64, 64'd0, 5'd5);
    n_total++; if (req_valid_o !== 1'b1) $display("FAIL basic_latency: req_valid=%b required 1", req_valid_o); else n_pass++;
    n_total++; if (req_src_o !== 64'h1_0000_1000) $display("FAIL basic_src: got %h required 100001000", req_src_o); else n_pass++;
    n_total++; if (req_dst_o !== 64'h2000 || req_len_o !== 64'd64 || req_2d_o !== 1'b0)
      $display("FAIL basic_fields: dst=%h len=%0d 2d=%b required 2000/64/0", req_dst_o, req_len_o, req_2d_o); else n_pass++;
    handshake();
    n_total++; if (acc_pvalid_o !== 1'b1) $display("FAIL basic_pvalid: got %b required 1", acc_pvalid_o); else n_pass++;
    take_wb(d, pid, seen);
    n_total++; if (!seen || d !== 64'd0 || pid !== 5'd5)
      $display("FAIL basic_wb: seen=%b pdata=%h pid=%0d required 1/0/5", seen, d, pid); else n_pass++;
    m_issue = m_issue + 32'd1;
    n_total++; if (acc_pvalid_o !== 1'b0 || acc_qready_o !== 1'b1 || busy_o !== 1'b1)
      $display("FAIL basic_idle: pvalid=%b qready=%b busy=%b required 0/1/1", acc_pvalid_o, acc_qready_o, busy_o); else n_pass++;
  endtask

  task automatic test_2d_copy();
    logic [63:0] d; logic [4:0] pid; bit sr, sw;
    apply_reset();
    wr_str(64'd8, 64'd16);
    wr_rep(64'd4);
    do_copy(1'b0, 64'd32, 5'd3, 5'd7, sr, sw, d, pid);
    n_total++; if (!sr || req_2d_o !== 1'b1 || req_decouple_o !== 1'b1)
      $display("FAIL twod_cfg: seen=%b 2d=%b dec=%b required 1/1/1", sr, req_2d_o, req_decouple_o); else n_pass++;
    n_total++; if (req_src_stride_o !== 64'd8 || req_dst_stride_o !== 64'd16 || req_reps_o !== 64'd4 || req_len_o !== 64'd32)
      $display("FAIL twod_fields: ss=%0d ds=%0d reps=%0d len=%0d required 8/16/4/32",
               req_src_stride_o, req_dst_stride_o, req_reps_o, req_len_o); else n_pass++;
    n_total++; if (!sw || d !== 64'd0 || pid !== 5'd7) $display("FAIL twod_id0: pdata=%h pid=%0d required 0/7", d, pid); else n_pass++;
    m_issue = m_issue + 32'd1;
    do_copy(1'b0, 64'd32, 5'd3, 5'd9, sr, sw, d, pid);
    n_total++; if (!sw || d !== 64'd1 || pid !== 5'd9) $display("FAIL twod_id1: pdata=%h pid=%0d required 1/9", d, pid); else n_pass++;
    m_issue = m_issue + 32'd1;
  endtask

  task automatic test_outstanding_limit();
    logic [63:0] d; logic [4:0] pid; bit sr, sw;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      do_copy(1'b1, 64'($urandom), 5'($urandom), 5'(i), sr, sw, d, pid);
      n_total++; if (!sw || d !== {32'd0, m_issue}) $display("FAIL limit_id%0d: pdata=%h required %h", i, d, m_issue); else n_pass++;
      m_issue = m_issue + 32'd1;
    end
    send_op(enc(F_CPY, 5'd1, 5'd2, 5'd3), 64'd128, 64'd0, 5'd3);
    repeat (4) @(negedge clk_i);
    n_total++; if (req_valid_o !== 1'b0) $display("FAIL limit_blocked: req_valid=%b required 0", req_valid_o); else n_pass++;
    n_total++; if (acc_qready_o !== 1'b0) $display("FAIL limit_qready: got %b required 0", acc_qready_o); else n_pass++;
    pulse_rsp();
    n_total++; if (req_valid_o !== 1'b1) $display("FAIL limit_release: req_valid=%b required 1", req_valid_o); else n_pass++;
    handshake();
    take_wb(d, pid, sw);
    n_total++; if (!sw || d !== 64'd8 || pid !== 5'd3) $display("FAIL limit_id8: pdata=%h pid=%0d required 8/3", d, pid); else n_pass++;
    m_issue = m_issue + 32'd1;
  endtask

  task automatic test_same_cycle();
    logic [63:0] d; logic [4:0] pid; bit sr, sw;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      do_copy(1'b0, 64'd16, 5'd0, 5'd1, sr, sw, d, pid);
      m_issue = m_issue + 32'd1;
    end
    send_op(enc(F_CPY, 5'd1, 5'd2, 5'd4), 64'd16, 64'd0, 5'd4);
    wait_req(sr);
    req_ready_i = 1'b1; rsp_valid_i = 1'b1;
    @(negedge clk_i);
    req_ready_i = 1'b0; rsp_valid_i = 1'b0;
    m_issue = m_issue + 32'd1; m_done = m_done + 32'd1;
    take_wb(d, pid, sw);
    n_total++; if (!sr || !sw || d !== 64'd3) $display("FAIL same_id: seen=%b/%b pdata=%h required 1/1/3", sr, sw, d); else n_pass++;
    for (int s = 0; s < 5; s++) begin
      logic [4:0] sel;
      sel = (s == 4) ? 5'd7 : 5'(s);
      do_stat(s[0], sel, 5'd12, d, pid, sw);
      n_total++; if (!sw || d !== m_status(sel) || pid !== 5'd12)
        $display("FAIL same_stat_sel%0d: pdata=%h pid=%0d required %h/12", sel, d, pid, m_status(sel)); else n_pass++;
    end
  endtask

  task automatic test_illegal();
    wr_src(64'hAAAA_5555, 64'h1234);
    send_op(enc(7'b0001001, 5'd0, 5'd0, 5'd0), 64'd1, 64'd2, 5'd3);
    n_total++; if (illegal_o !== 1'b1 || acc_pvalid_o !== 1'b0)
      $display("FAIL illegal_f7: illegal=%b pvalid=%b required 1/0", illegal_o, acc_pvalid_o); else n_pass++;
    @(negedge clk_i);
    n_total++; if (illegal_o !== 1'b0 || acc_pvalid_o !== 1'b0)
      $display("FAIL illegal_pulse: illegal=%b pvalid=%b required 0/0", illegal_o, acc_pvalid_o); else n_pass++;
    send_op(enc(F_SRC, 5'd1, 5'd2, 5'd3), 64'hDEAD, 64'hBEEF, 5'd3);
    n_total++; if (illegal_o !== 1'b1 || req_src_o !== m_src)
      $display("FAIL illegal_rd: illegal=%b src=%h required 1/%h", illegal_o, req_src_o, m_src); else n_pass++;
    send_op(enc(F_STAT, 5'd1, 5'd4, 5'd3), 64'd0, 64'd1, 5'd3);
    repeat (2) @(negedge clk_i);
    n_total++; if (acc_pvalid_o !== 1'b0 || acc_qready_o !== 1'b1)
      $display("FAIL illegal_stat_rs1: pvalid=%b qready=%b required 0/1", acc_pvalid_o, acc_qready_o); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [63:0] d; logic [4:0] pid; bit sr, sw;
    apply_reset();
    do_copy(1'b1, 64'd8, 5'd0, 5'd2, sr, sw, d, pid);
    m_issue = m_issue + 32'd1;
    send_op(enc(F_STATI, 5'd1, 5'd0, 5'd6), 64'd0, 64'd0, 5'd6);
    n_total++; if (acc_pvalid_o !== 1'b1) $display("FAIL rstmid_resp: pvalid=%b required 1", acc_pvalid_o); else n_pass++;
    rst_i = 1'b1;
    @(negedge clk_i);
    n_total++; if (acc_pvalid_o !== 1'b0 || req_valid_o !== 1'b0 || acc_qready_o !== 1'b1)
      $display("FAIL rstmid_outs: pvalid=%b req_valid=%b qready=%b required 0/0/1", acc_pvalid_o, req_valid_o, acc_qready_o); else n_pass++;
    rst_i = 1'b0;
    model_reset();
    do_stat(1'b0, 5'd1, 5'd6, d, pid, sw);
    n_total++; if (!sw || d !== 64'd0) $display("FAIL rstmid_issue: pdata=%h required 0", d); else n_pass++;
    send_op(enc(F_CPYI, 5'd0, 5'd1, 5'd2), 64'd8, 64'd0, 5'd2);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    n_total++; if (req_valid_o !== 1'b0 || acc_qready_o !== 1'b1 || busy_o !== 1'b0)
      $display("FAIL rstmid_issue_drop: req_valid=%b qready=%b busy=%b required 0/1/0", req_valid_o, acc_qready_o, busy_o); else n_pass++;
  endtask

  task automatic test_random();
    logic [63:0] d, a, b; logic [4:0] pid, sel, qid; bit sr, sw;
    apply_reset();
    for (int it = 0; it < 80; it++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; qid = 5'($urandom);
      case ($urandom_range(0, 7))
        0: begin wr_src(a, b); n_total++; if (req_src_o !== m_src) $display("FAIL rnd_src: got %h required %h", req_src_o, m_src); else n_pass++; end
        1: begin wr_dst(a, b); n_total++; if (req_dst_o !== m_dst) $display("FAIL rnd_dst: got %h required %h", req_dst_o, m_dst); else n_pass++; end
        2: begin wr_str(a, b); n_total++; if (req_src_stride_o !== m_sstr || req_dst_stride_o !== m_dstr)
             $display("FAIL rnd_str: got %h/%h required %h/%h", req_src_stride_o, req_dst_stride_o, m_sstr, m_dstr); else n_pass++; end
        3: begin wr_rep(a); n_total++; if (req_reps_o !== m_reps) $display("FAIL rnd_rep: got %h required %h", req_reps_o, m_reps); else n_pass++; end
        4: begin wr_user(a, b); n_total++; if (req_user_o !== m_user) $display("FAIL rnd_user: got %h required %h", req_user_o, m_user); else n_pass++; end
        5, 6: begin
          if (m_issue - m_done == 32'd8) pulse_rsp();
          do_copy(1'($urandom), a, 5'($urandom), qid, sr, sw, d, pid);
          n_total++; if (!sr || !sw || d !== {32'd0, m_issue} || pid !== qid)
            $display("FAIL rnd_cpy_id: seen=%b/%b pdata=%h pid=%0d required %h/%0d", sr, sw, d, pid, m_issue, qid); else n_pass++;
          n_total++; if (req_len_o !== m_len || {req_2d_o, req_decouple_o} !== m_cfg || req_src_o !== m_src || req_dst_o !== m_dst)
            $display("FAIL rnd_cpy_fields: len=%h cfg=%b src=%h dst=%h required %h/%b/%h/%h",
                     req_len_o, {req_2d_o, req_decouple_o}, req_src_o, req_dst_o, m_len, m_cfg, m_src, m_dst); else n_pass++;
          m_issue = m_issue + 32'd1;
        end
        default: begin
          if ($urandom_range(0, 1) == 0) begin
            pulse_rsp();
          end else begin
            sel = 5'($urandom_range(0, 5));
            do_stat(1'($urandom), sel, qid, d, pid, sw);
            n_total++; if (!sw || d !== m_status(sel) || pid !== qid)
              $display("FAIL rnd_stat_sel%0d: pdata=%h pid=%0d required %h/%0d", sel, d, pid, m_status(sel), qid); else n_pass++;
          end
        end
      endcase
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_copy();
    test_2d_copy();
    test_outstanding_limit();
    test_same_cycle();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/idma_inst64_cmd_sequencer.md
Name: idma_inst64_cmd_sequencer

Overview:
Controller between the Snitch accelerator offload port and the iDMA backend request channel. It decodes the inst64 DMA instructions (DMSRC, DMDST, DMCPYI, DMCPY, DMSTATI, DMSTAT, DMSTR, DMREP, DMUSER) and accumulates transfer configuration in shadow registers. On DMCPY/DMCPYI it sequences one backend request and returns a transfer ID, and on DMSTAT/DMSTATI it returns status. It also tracks issued and completed transfers and enforces an outstanding-transfer limit.

Parameters:
AddrWidth, 64, backend address and stride width
UserWidth, 32, user field width
IdWidth, 32, transfer counter width (wraps modulo 2^IdWidth)
MaxOutstanding, 8, maximum issued-but-not-completed transfers (1..2^IdWidth-1)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
acc_qvalid_i  in  1  offload request valid
acc_qready_o  out  1  offload request ready
acc_qdata_op_i  in  32  instruction word
acc_qdata_arga_i  in  64  rs1 value
acc_qdata_argb_i  in  64  rs2 value
acc_qid_i  in  5  destination register id
acc_pvalid_o  out  1  writeback valid
acc_pready_i  in  1  writeback ready
acc_pdata_o  out  64  writeback data (zero-extended)
acc_pid_o  out  5  writeback register id
req_valid_o  out  1  backend request valid
req_ready_i  in  1  backend request ready
req_src_o / req_dst_o  out  AddrWidth  addresses
req_len_o  out  AddrWidth  length in bytes
req_src_stride_o / req_dst_stride_o  out  AddrWidth  2D strides
req_reps_o  out  AddrWidth  2D repetitions
req_2d_o  out  1  2D enable
req_decouple_o  out  1  decouple read/write
req_user_o  out  UserWidth  user field
rsp_valid_i  in  1  one-cycle pulse per completed transfer
busy_o  out  1  outstanding != 0
illegal_o  out  1  one-cycle pulse on undecodable op

Behaviour:
- Decode: opcode[6:0]=0101011, funct3=000, funct7 selects the instruction. Every field that the encoding fixes to zero (rd, rs1 or rs2 as applicable) must be zero; otherwise the op is illegal.
- Shadow register writes, one cycle, no writeback:
  - DMSRC: src={argb[31:0],arga[31:0]}[AddrWidth-1:0]. DMDST likewise for dst.
  - DMSTR: src_stride=arga, dst_stride=argb (truncated to AddrWidth).
  - DMREP: reps=arga.
  - DMUSER: user={argb[31:0],arga[31:0]}[UserWidth-1:0].
- Config word cfg: DMCPYI uses op[24:20]; DMCPY uses argb[4:0]. cfg[0] is decouple, cfg[1] is 2D. Length is arga.
- Status selector sel: DMSTATI uses op[24:20]; DMSTAT uses argb[4:0].
  - 0: done count. Transfers with ID < done count are complete (mod wrap).
  - 1: issue count, i.e. the next ID.
  - 2: busy.
  - 3: outstanding == MaxOutstanding.
  - Any other value returns 0.
- FSM states: IDLE, ISSUE, RESP. acc_qready_o=1 only in IDLE.
  - IDLE + accepted register-write op: stay in IDLE.
  - IDLE + accepted illegal op: stay in IDLE, pulse illegal_o next cycle, no writeback.
  - IDLE + accepted DMCPY/DMCPYI: latch len, cfg and qid, go to ISSUE.
  - IDLE + accepted DMSTAT/DMSTATI: latch qid, go to RESP with pdata = status evaluated in the accept cycle.
  - ISSUE: req_valid_o=1 iff outstanding < MaxOutstanding. req_* outputs are stable while valid. On req_valid_o & req_ready_i: pdata = issue count, issue count increments, go to RESP.
  - RESP: acc_pvalid_o=1 and data held until acc_pready_i, then go to IDLE.
- Counters:
  - outstanding = issue − done (mod 2^IdWidth).
  - An rsp_valid_i pulse while outstanding == 0 is ignored; done does not increment.
  - Issue and completion in the same cycle: both counters increment, so outstanding is unchanged.
  - Completion is counted in every state.
- Reset values: all shadow registers, counters and cfg = 0; state IDLE; all valid and pulse outputs 0; acc_qready_o = 1 in the first cycle after reset. Reset mid-ISSUE or mid-RESP drops the pending request and writeback.
- Minimum latency: accept to req_valid_o is 1 cycle; req handshake to acc_pvalid_o is 1 cycle.

Test Plan:
- DMSRC(arga=0x1000, argb=0x1), DMDST(0x2000, 0), then DMCPYI(len=64, imm=0) with qid=5 -> req_valid_o with src=0x1_0000_1000, dst=0x2000, len=64, 2d=0. After the handshake: pvalid, pdata=0, pid=5.
- DMSTR(8, 16), DMREP(4), DMCPY(len=32, argb=3) -> req_2d_o=1, decouple=1, strides 8/16, reps=4. A second DMCPY returns ID 1.
- Issue 8 transfers with no completions, then a 9th DMCPY -> req_valid_o stays 0 and DMSTATI sel=3 cannot run (qready=0). One rsp_valid_i pulse -> the 9th issues the next cycle with ID 8.
- Same-cycle req handshake and rsp_valid_i at outstanding=3 -> outstanding stays 3. Then DMSTAT sel=2 returns 1 and sel=7 returns 0.
- Op with funct7=0001001, or DMSRC with rd≠0 -> accepted, illegal_o pulses once, no writeback, no shadow register change.
- rst_i asserted while in RESP with acc_pready_i=0 -> next cycle pvalid=0, req_valid=0, qready=1. DMSTAT sel=1 then returns 0.
